// File: rtl/rv_pkg.sv
// Shared RV32I definitions: instruction classes, encoding fields, loader states.
package rv_pkg;

   // Symbolic instruction classes accepted by the loader (same set as the decoder)
   typedef enum logic [3:0] {
      LW   = 4'd0,
      SW   = 4'd1,
      ADD  = 4'd2,
      SUB  = 4'd3,
      AND  = 4'd4,
      OR   = 4'd5,
      SLT  = 4'd6,
      BEQ  = 4'd7,
      ADDI = 4'd8,
      JAL  = 4'd9,
      LUI  = 4'd10
   } instr_class_t;

   // Major opcodes
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   // funct3 values
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_SW   = 3'b010;
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_ADDI = 3'b000;

   // funct7 values (sub differs from add only here)
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   // Loader FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } loader_state_t;

endpackage

// File: rtl/instr_encoder.sv
// Combinational encoder: symbolic descriptor -> RV32I instruction word.
// Register fields not used by a format are left zero; unsupported classes flag illegal.
module instr_encoder
   import rv_pkg::*;
(
   input  logic [3:0]  cls_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [31:0] imm_i,
   output logic [31:0] word_o,
   output logic        illegal_o
);

   // Branch/jump offsets are halfword aligned, so bit 0 never reaches the word
   logic unused_imm;
   assign unused_imm = imm_i[0];

   // Assemble the instruction fields for each supported class
   always_comb begin
      word_o    = '0;
      illegal_o = 1'b0;
      case (cls_i)
         LW:   word_o = {imm_i[11:0], rs1_i, F3_LW, rd_i, OPC_LOAD};
         SW:   word_o = {imm_i[11:5], rs2_i, rs1_i, F3_SW, imm_i[4:0], OPC_STORE};
         ADD:  word_o = {F7_BASE, rs2_i, rs1_i, F3_ADD, rd_i, OPC_OP};
         SUB:  word_o = {F7_SUB,  rs2_i, rs1_i, F3_ADD, rd_i, OPC_OP};
         AND:  word_o = {F7_BASE, rs2_i, rs1_i, F3_AND, rd_i, OPC_OP};
         OR:   word_o = {F7_BASE, rs2_i, rs1_i, F3_OR,  rd_i, OPC_OP};
         SLT:  word_o = {F7_BASE, rs2_i, rs1_i, F3_SLT, rd_i, OPC_OP};
         BEQ:  word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ,
                         imm_i[4:1], imm_i[11], OPC_BRANCH};
         ADDI: word_o = {imm_i[11:0], rs1_i, F3_ADDI, rd_i, OPC_OPIMM};
         JAL:  word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
         LUI:  word_o = {imm_i[31:12], rd_i, OPC_LUI};
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/imem_program_loader.sv
// Program loader: encodes a stream of instruction descriptors and writes them
// to instruction memory from word 0, holding the core in reset until complete.
module imem_program_loader
   import rv_pkg::*;
#(
   parameter  int unsigned DEPTH = 64,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_class,
   input  logic [4:0]    in_rd,
   input  logic [4:0]    in_rs1,
   input  logic [4:0]    in_rs2,
   input  logic [31:0]   in_imm,
   input  logic          in_last,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          core_reset,
   output logic          done,
   output logic          err
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   loader_state_t state_q, state_d;
   logic [AW-1:0] count_q, count_d;
   logic          full_q,  full_d;
   logic          err_q,   err_d;
   logic          we_q,    we_d;
   logic [AW-1:0] addr_q,  addr_d;
   logic [31:0]   wdata_q, wdata_d;

   logic [31:0]   enc_word;
   logic          enc_illegal;

   instr_encoder u_enc (
      .cls_i     (in_class),
      .rd_i      (in_rd),
      .rs1_i     (in_rs1),
      .rs2_i     (in_rs2),
      .imm_i     (in_imm),
      .word_o    (enc_word),
      .illegal_o (enc_illegal)
   );

   // State, counter and registered write port
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         full_q  <= full_d;
         err_q   <= err_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Next-state, handshake and write generation
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      full_d   = full_q;
      err_d    = err_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      in_ready = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               count_d = '0;
               full_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         LOAD: begin
            in_ready = ~full_q;
            if (in_valid && !full_q) begin
               if (enc_illegal) begin
                  err_d = 1'b1;
               end else begin
                  we_d    = 1'b1;
                  addr_d  = count_q;
                  wdata_d = enc_word;
                  count_d = count_q + AW'(1);
                  // Memory is now full; count has wrapped and must not be reused
                  if (count_q == LAST_ADDR) full_d = 1'b1;
               end
               if (in_last) state_d = DONE;
            end else if (in_valid && full_q) begin
               // A descriptor beyond capacity is refused and ends the load
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (start) begin
               state_d = LOAD;
               count_d = '0;
               full_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign err        = err_q;
   assign done       = (state_q == DONE);
   assign core_reset = (state_q != DONE);

endmodule
